// File: rtl/tff_chk_pkg.sv
// Shared types and constants for the tff stimulus generator / checker.
// Latency: n/a (declarations only). Backpressure: n/a.
package tff_chk_pkg;

  localparam int LFSR_W  = 16;
  localparam int ERR_W   = 8;
  localparam int TRACE_W = 19;
  localparam int CNT_W   = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WAIT,
    APPLY,
    DRAIN,
    DONE
  } chk_state_e;

  // Right-shifting Galois step; the feedback bit is the outgoing LSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/tff_chk_if.sv
// DUT-facing bus of the checker: stimulus out, q back, plus the trace strobe.
// Latency: wiring only. Backpressure: none, trace consumer must accept every strobe.
interface tff_chk_if;
  import tff_chk_pkg::*;

  logic               dut_rstn;
  logic               dut_t;
  logic               dut_q;
  logic               trace_valid;
  logic [TRACE_W-1:0] trace_data;

  modport master (
    output dut_rstn,
    output dut_t,
    output trace_valid,
    output trace_data,
    input  dut_q
  );

  modport slave (
    input  dut_rstn,
    input  dut_t,
    input  trace_valid,
    input  trace_data,
    output dut_q
  );

endinterface

// File: rtl/tff_chk_lfsr.sv
// 16-bit Galois LFSR with synchronous seed load and advance enable.
// Latency: new state visible the cycle after load/advance. Backpressure: none.
module tff_chk_lfsr
  import tff_chk_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (adv_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/tff_stim_check.sv
// Self-test stimulus generator and q checker for a toggle flip-flop; TFF_CHK_TRACE_EN adds a per-cycle trace.
// Latency: run = HOLD_CYC + sum(delay+1) + DRAIN_CYC cycles busy, verdict on the following cycle.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while a run is busy.
module tff_stim_check
  import tff_chk_pkg::*;
#(
  parameter int               NUM_STEPS = 20,
  parameter int               DLY_W     = 5,
  parameter int               HOLD_CYC  = 2,
  parameter int               DRAIN_CYC = 4,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  tff_chk_if.master        bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  chk_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        step_q, step_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              rstn_q, rstn_d;
  logic              t_q, t_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              exp_q;

  logic              start_acc;
  logic              lfsr_adv;
  logic              chk_en;
  logic              mismatch;
  logic              go_step;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [DLY_W-1:0]  dly_sel;

  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign lfsr_adv  = (state_q == APPLY);
  assign lfsr_nxt  = lfsr_step(lfsr);
  // HOLD exits with the seed's delay; APPLY picks the delay of the state it advances to.
  assign dly_sel   = (state_q == HOLD) ? lfsr[DLY_W-1:0] : lfsr_nxt[DLY_W-1:0];

  tff_chk_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (start_acc),
    .adv_i   (lfsr_adv),
    .state_o (lfsr)
  );

  assign chk_en = (state_q == WAIT) || (state_q == APPLY) || (state_q == DRAIN) ||
                  ((state_q == HOLD) && !rstn_q);
  assign mismatch = (bus.dut_q != exp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rstn_d  = rstn_q;
    t_d     = t_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    go_step = 1'b0;

    if (chk_en && mismatch && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC);
          step_d  = '0;
          rstn_d  = 1'b0;
          t_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q <= CNT_W'(1)) begin
          rstn_d  = 1'b1;
          go_step = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      APPLY: begin
        t_d    = lfsr[LFSR_W-1];
        step_d = step_q + 8'd1;
        if (step_d == 8'(NUM_STEPS)) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC);
        end else begin
          go_step = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // WAIT is loaded with delay-1 (or skipped) so each step spans delay+1 cycles including APPLY.
    if (go_step) begin
      if (dly_sel == '0) begin
        state_d = APPLY;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_W'(dly_sel) - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      err_q   <= '0;
      rstn_q  <= 1'b0;
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      err_q   <= err_d;
      rstn_q  <= rstn_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      // Reference tff fed by the same registered stimulus the DUT samples.
      exp_q   <= rstn_q ? (exp_q ^ t_q) : 1'b0;
    end
  end

  assign bus.dut_rstn = rstn_q;
  assign bus.dut_t    = t_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_q;

`ifdef TFF_CHK_TRACE_EN
  logic [15:0]        cyc_q;
  logic               trc_vld_q;
  logic [TRACE_W-1:0] trc_dat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_q     <= '0;
      trc_vld_q <= 1'b0;
      trc_dat_q <= '0;
    end else begin
      cyc_q     <= start_acc ? 16'd0 : cyc_q + 16'd1;
      trc_vld_q <= busy_q;
      trc_dat_q <= {cyc_q, rstn_q, t_q, bus.dut_q};
    end
  end

  assign bus.trace_valid = trc_vld_q;
  assign bus.trace_data  = trc_dat_q;
`else
  assign bus.trace_valid = 1'b0;
  assign bus.trace_data  = '0;
`endif

endmodule

// File: tb/tb_tff_stim_check.sv
// Bench for tff_stim_check: a behavioural tff (optionally stuck/inverted) closes the loop.
// Expected per-cycle stimulus and per-run verdicts are queued at issue time and popped by a monitor.
module tb_tff_stim_check;

  localparam int          NUM_STEPS  = 20;
  localparam int          DLY_W      = 5;
  localparam int          HOLD_CYC   = 2;
  localparam int          DRAIN_CYC  = 4;
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int          M_OK       = 0;
  localparam int          M_STUCK    = 1;
  localparam int          M_INV      = 2;
  localparam int          DONE_LIMIT = 5000;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic       tff_q = 1'b0;
  int         qmode = M_OK;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int cycles;
    bit pass;
    int err;
  } run_t;

  run_t       exp_run_q[$];
  logic [1:0] exp_cyc_q[$];
  int         step7_base;
  int         last_busy;
  int         trace_seen = 0;

  // Hand-derived from SEED: delays 1,16,24 and t = 1,1,0 for the first steps.
  int   hand_cyc[4] = '{3, 4, 45, 46};
  logic hand_t[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};

  tff_chk_if bus ();

  always #5 clk = ~clk;

  always @(posedge clk) tff_q <= bus.dut_rstn ? (tff_q ^ bus.dut_t) : 1'b0;

  assign bus.dut_q = (qmode == M_STUCK) ? 1'b0 : (qmode == M_INV) ? ~tff_q : tff_q;

  tff_stim_check #(
    .NUM_STEPS (NUM_STEPS),
    .DLY_W     (DLY_W),
    .HOLD_CYC  (HOLD_CYC),
    .DRAIN_CYC (DRAIN_CYC),
    .SEED      (SEED)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_chk++;
    $display("FAIL %s: expected event absent, required present", name);
  endtask

  function automatic logic [15:0] galois(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int miss(input int mode, input logic e);
    if (mode == M_INV) return 1;
    if (mode == M_STUCK && e) return 1;
    return 0;
  endfunction

  // Queue the busy-cycle stream {dut_rstn,dut_t} and the verdict; stuck mode assumes a reset-fresh start.
  task automatic push_run(input int mode);
    logic [15:0] s;
    logic        t_cur, e;
    int          b, err, d;
    run_t        r;
    s = SEED; t_cur = 1'b0; e = 1'b0; b = 0; err = 0;
    for (int h = 0; h < HOLD_CYC; h++) begin
      exp_cyc_q.push_back(2'b00);
      err += miss(mode, e);
      e = 1'b0;
      b++;
    end
    for (int i = 0; i < NUM_STEPS; i++) begin
      d = int'(s[DLY_W-1:0]);
      if (i == 7) step7_base = b;
      for (int k = 0; k <= d; k++) begin
        exp_cyc_q.push_back({1'b1, t_cur});
        err += miss(mode, e);
        e = e ^ t_cur;
        b++;
      end
      t_cur = s[15];
      s = galois(s);
    end
    for (int k = 0; k < DRAIN_CYC; k++) begin
      exp_cyc_q.push_back({1'b1, t_cur});
      err += miss(mode, e);
      e = e ^ t_cur;
      b++;
    end
    last_busy = b;
    r.cycles = b + 1;
    r.pass   = (err == 0);
    r.err    = (err > 255) ? 255 : err;
    exp_run_q.push_back(r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < DONE_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      flag(name);
      exp_cyc_q.delete();
      exp_run_q.delete();
    end
  endtask

  initial begin : monitor
    logic       done_prev;
    logic [1:0] e, last;
    int         bcnt, tcnt;
    run_t       r;
    done_prev = 1'b0; bcnt = 0; tcnt = 0; last = 2'b00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bcnt = 0; tcnt = 0; done_prev = 1'b0;
      end else begin
`ifdef TFF_CHK_TRACE_EN
        if (bus.trace_valid) begin
          if (tcnt == 0) chk("trace_first_cycle", 32'(bus.trace_data[18:3]), 0);
          chk("trace_rstn_t", 32'(bus.trace_data[2:1]), 32'(last));
          tcnt++;
        end
`else
        if (bus.trace_valid) trace_seen++;
`endif
        if (busy) begin
          for (int j = 0; j < 4; j++)
            if (bcnt == hand_cyc[j]) chk("hand_t", 32'(bus.dut_t), 32'(hand_t[j]));
          if (exp_cyc_q.size() == 0) begin
            flag("stream_underflow");
          end else begin
            e = exp_cyc_q.pop_front();
            chk("rstn_t_stream", 32'({bus.dut_rstn, bus.dut_t}), 32'(e));
            last = e;
          end
          bcnt++;
        end
        if (done && !done_prev) begin
          if (exp_run_q.size() == 0) begin
            flag("verdict_underflow");
          end else begin
            r = exp_run_q.pop_front();
            chk("cycles_to_done", bcnt + 1, r.cycles);
            chk("pass", 32'(pass), 32'(r.pass));
            chk("err_cnt", 32'(err_cnt), r.err);
            chk("busy_low_at_done", 32'(busy), 0);
`ifdef TFF_CHK_TRACE_EN
            chk("trace_count", tcnt, bcnt);
`endif
          end
          bcnt = 0; tcnt = 0;
        end
        done_prev = done;
      end
    end
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dut_rstn", 32'(bus.dut_rstn), 0);
    chk("rst_dut_t", 32'(bus.dut_t), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_trace_valid", 32'(bus.trace_valid), 0);
    chk("rst_trace_data", 32'(bus.trace_data), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Run 1: clean run.
    push_run(M_OK);
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    wait_done("run1_done_timeout");

    // Run 2: start held into HOLD and pulsed in DRAIN, both ignored.
    push_run(M_OK);
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (last_busy - 3) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("run2_done_timeout");

    // Run 3: inverted q, error count saturates.
    qmode = M_INV;
    push_run(M_INV);
    pulse_start();
    wait_done("run3_done_timeout");

    // Run 4: start held high from DONE restarts and clears the count.
    qmode = M_OK;
    push_run(M_OK);
    start = 1'b1;
    @(posedge clk); #1;
    chk("err_clr_on_start", 32'(err_cnt), 0);
    chk("done_clr_on_start", 32'(done), 0);
    chk("pass_clr_on_start", 32'(pass), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("run4_done_timeout");

    // Run 5: reset during WAIT of step 7 aborts without a verdict.
    push_run(M_OK);
    pulse_start();
    repeat (step7_base + 2) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    exp_cyc_q.delete();
    exp_run_q.delete();
    @(posedge clk); #1;
    chk("abort_dut_rstn", 32'(bus.dut_rstn), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err_cnt", 32'(err_cnt), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Run 6: q stuck at 0 straight after reset.
    qmode = M_STUCK;
    push_run(M_STUCK);
    pulse_start();
    wait_done("run6_done_timeout");

    // Run 7: clean run after the abort reproduces the same sequence.
    qmode = M_OK;
    push_run(M_OK);
    pulse_start();
    wait_done("run7_done_timeout");

    repeat (3) @(posedge clk);
    #1;
`ifndef TFF_CHK_TRACE_EN
    chk("trace_never_valid", trace_seen, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tff_stim_check.md
Name: tff_stim_check

Overview:
- Synthesizable stimulus generator and response checker for the toggle flip-flop (tff).
- Drives the DUT's reset and t inputs with a reproducible pseudo-random toggle sequence.
- Checks q every cycle against an internal reference model and reports a pass/fail verdict with an error count.
- Sits beside tff in on-chip self-test and replaces free-running $random stimulus.

Parameters:
NUM_STEPS, 20, number of t updates applied per run (1..255)
DLY_W, 5, width of the random inter-step delay field; delay range 0..2^DLY_W-1 cycles
HOLD_CYC, 2, cycles dut_rstn is held low at run start (>=1)
DRAIN_CYC, 4, cycles of checking after the last step before DONE
SEED, 16'hACE1, LFSR seed; must be nonzero

Ports:
clk  in  1  single clock; all logic on posedge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
dut_q  in  1  q output of the DUT
dut_rstn  out  1  reset to the DUT, registered
dut_t  out  1  t input to the DUT, registered
busy  out  1  high from the cycle after accepted start until DONE is entered
done  out  1  sticky high in DONE until next accepted start
pass  out  1  valid when done=1; 1 if err_cnt==0
err_cnt  out  8  saturating mismatch count (max 255)
trace_valid  out  1  trace strobe (see Optional Feature)
trace_data  out  19  {cycle[15:0], dut_rstn, dut_t, dut_q}

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, dut_rstn=0, dut_t=0, busy=0, done=0, pass=0, err_cnt=0, exp_q=0, lfsr=SEED, step counter=0, trace outputs=0. Reset mid-run aborts the run with no partial verdict.
- LFSR: 16-bit Galois, taps 0xB400, shifts once per APPLY. Reloads SEED on each accepted start, so every run is identical.
- FSM transitions:
  - IDLE: start=1 -> HOLD; clear err_cnt, done, pass; dut_rstn=0, dut_t=0; hold counter=HOLD_CYC.
  - HOLD: hold counter decrements; when it reaches 1, set dut_rstn=1 and go to WAIT; delay counter=lfsr[DLY_W-1:0].
  - WAIT: delay counter==0 -> APPLY, otherwise decrement.
  - APPLY (one cycle): dut_t<=lfsr[15]; advance lfsr; step++. If step==NUM_STEPS -> DRAIN with counter=DRAIN_CYC; else -> WAIT with delay=next lfsr[DLY_W-1:0].
  - DRAIN: count down to 0, then -> DONE.
  - DONE: done=1, pass=(err_cnt==0). start -> HOLD (new run).
- Each step therefore takes delay+1 cycles; delay=0 applies t on the next cycle.
- start is ignored in HOLD/WAIT/APPLY/DRAIN.
- Reference model: each posedge, exp_q<=0 if dut_rstn==0, else exp_q<=exp_q^dut_t. This uses the same registered values the DUT samples, so it has zero latency relative to the DUT.
- Check: in WAIT, APPLY, DRAIN, and in HOLD cycles where dut_rstn==0, if dut_q!=exp_q then err_cnt++ (saturating at 255). No checking in IDLE/DONE.
- dut_t holds its value between steps and is not cleared in DONE. It is cleared only on start and on reset.

Optional Feature:
- Macro TFF_CHK_TRACE_EN.
- Defined: 16-bit free-running cycle counter, cleared on accepted start. trace_valid=1 every cycle while busy, with trace_data={cycle, dut_rstn, dut_t, dut_q} registered one cycle after the sampled values. This gives a logger the same data as a time,rstn,t,q CSV.
- Undefined: counter not built; trace_valid and trace_data tied to 0. Ports remain present.

Decomposition:
- Package tff_chk_pkg holds: state enum (IDLE, HOLD, WAIT, APPLY, DRAIN, DONE), LFSR_TAPS=16'hB400, LFSR_W=16, ERR_W=8, TRACE_W=19.
- One sub-module, tff_chk_lfsr: seed load, advance enable, 16-bit state output.
- Reference model, checker and FSM stay in the top module.

Test Plan:
- Correct tff connected, start pulse -> busy high; done after exactly HOLD_CYC + sum(delay_i+1) + DRAIN_CYC + 1 cycles; pass=1, err_cnt=0.
- DUT q stuck at 0 -> done=1, pass=0, err_cnt equals the number of cycles the model's exp_q was 1 (bench model computes it).
- DUT q inverted -> err_cnt counts every checked cycle; with DLY_W=8 and NUM_STEPS=255 it saturates at 255, no wrap.
- rstn pulsed low during WAIT of step 7 -> next cycle dut_rstn=0, busy=0, done=0, err_cnt=0; later start -> full run identical to the first (same dut_t sequence).
- start pulsed in HOLD and DRAIN -> ignored, cycle count unchanged. start held in DONE -> new run with err_cnt cleared.
- TFF_CHK_TRACE_EN defined -> trace_valid count equals busy cycle count, first trace cycle field=0, t bits match the LFSR sequence. Undefined -> trace_valid never 1.
